// File: rtl/led_seq_pkg.sv
// Shared encodings and seed helper for the LED sequencer and its later display stages.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_ROTATE = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_COUNT  = 2'd3
  } mode_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  localparam int SEED_W = 32;

  // Single-lit patterns start at LED0; BLINK and COUNT start dark.
  function automatic logic [SEED_W-1:0] seed_of(input mode_e mode, input int width);
    logic [SEED_W-1:0] s;
    s = (mode == MODE_ROTATE || mode == MODE_BOUNCE) ? SEED_W'(1) : '0;
    return s & ((SEED_W'(1) << width) - SEED_W'(1));
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides an incoming tick strobe down to one step every STEP_DIV unpaused ticks.
module tick_prescaler #(
  parameter int STEP_DIV = 1,
  localparam int PW = $clog2(STEP_DIV) + 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic hold,
  input  logic clear,
  output logic step
);

  logic [PW-1:0] presc_q, presc_d;
  logic          at_last;

  assign at_last = (presc_q == PW'(STEP_DIV - 1));
  assign step    = tick & ~hold & at_last;

  always_comb begin
    presc_d = presc_q;
    if (clear) begin
      presc_d = '0;
    end else if (tick && !hold) begin
      presc_d = at_last ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/led_sequencer.sv
// Steps one of four LED patterns per prescaled tick and flags each completed pattern cycle.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_DIV = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [1:0]       mode,
  input  logic             mode_load,
  input  logic             pause,
  output logic [WIDTH-1:0] leds,
  output logic             wrap,
  output logic [1:0]       mode_q
);

  localparam logic [WIDTH-1:0] LED_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  mode_e            mode_cur_q, mode_cur_d;
  logic [WIDTH-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic             wrap_q, wrap_d;
  logic             step;

  tick_prescaler #(.STEP_DIV(STEP_DIV)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .hold  (pause),
    .clear (mode_load),
    .step  (step)
  );

  // mode_load outranks a coincident step, so the step is simply dropped.
  always_comb begin
    mode_cur_d = mode_cur_q;
    leds_d     = leds_q;
    dir_d      = dir_q;
    wrap_d     = 1'b0;
    if (mode_load) begin
      mode_cur_d = mode_e'(mode);
      leds_d     = WIDTH'(seed_of(mode_e'(mode), WIDTH));
      dir_d      = DIR_LEFT;
    end else if (step) begin
      case (mode_cur_q)
        MODE_BLINK: begin
          leds_d = {WIDTH{~leds_q[0]}};
          wrap_d = leds_q[0];
        end
        MODE_ROTATE: begin
          leds_d = {leds_q[WIDTH-2:0], leds_q[WIDTH-1]};
          wrap_d = (leds_q == LED_MSB);
        end
        MODE_BOUNCE: begin
          if (dir_q == DIR_LEFT) begin
            leds_d = leds_q << 1;
            if (leds_d == LED_MSB) dir_d = DIR_RIGHT;
          end else begin
            leds_d = leds_q >> 1;
            if (leds_d == LED_ONE) begin
              dir_d  = DIR_LEFT;
              wrap_d = 1'b1;
            end
          end
        end
        MODE_COUNT: begin
          leds_d = leds_q + 1'b1;
          wrap_d = &leds_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_cur_q <= MODE_BLINK;
      leds_q     <= '0;
      dir_q      <= DIR_LEFT;
      wrap_q     <= 1'b0;
    end else begin
      mode_cur_q <= mode_cur_d;
      leds_q     <= leds_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
    end
  end

  assign leds   = leds_q;
  assign wrap   = wrap_q;
  assign mode_q = mode_cur_q;

endmodule
